// File: rtl/uart_pkg.sv
// Shared types and default framing constants for the UART receive path.
package uart_pkg;

    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned DefaultOsr   = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one tick every baud_div+1 clocks.
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == baud_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer feeding the RX FIFO write port; registered
// write strobe and single-cycle framing/parity/overrun error pulses.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = DefaultDataW,
    parameter int unsigned OSR        = DefaultOsr,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              wrt_clk,
    input  logic              wrst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              rx_in,
    input  logic              wfull,
    output logic              wrt_en,
    output logic [DATA_W-1:0] wrt_data,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun_err
);

    localparam int unsigned SW = $clog2(OSR);
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [SW-1:0] HalfLast = SW'(OSR / 2 - 1);
    localparam logic [SW-1:0] BitLast  = SW'(OSR - 1);
    localparam logic [BW-1:0] DataLast = BW'(DATA_W - 1);
    localparam logic          OddBit   = (PARITY_ODD != 0);
    localparam logic          ParityOn = (PARITY_EN != 0);

    logic              tick;
    logic              rx_meta;
    logic              rx_s;
    rx_state_e         state;
    logic [SW-1:0]     sample_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bad;

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk     (wrt_clk),
        .rst     (wrst),
        .baud_div(baud_div),
        .tick    (tick)
    );

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge wrt_clk or posedge wrst) begin
        if (wrst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge wrt_clk or posedge wrst) begin
        if (wrst) begin
            state       <= StIdle;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bad     <= 1'b0;
            wrt_en      <= 1'b0;
            wrt_data    <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            wrt_en      <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            if (tick) begin
                case (state)
                    StIdle: begin
                        if (!rx_s) begin
                            state      <= StStart;
                            sample_cnt <= '0;
                            par_bad    <= 1'b0;
                        end
                    end
                    StStart: begin
                        if (sample_cnt == HalfLast) begin
                            if (rx_s) begin
                                state <= StIdle;
                            end else begin
                                state      <= StData;
                                sample_cnt <= '0;
                                bit_cnt    <= '0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    StData: begin
                        if (sample_cnt == BitLast) begin
                            // LSB arrives first and ends up at bit 0 after DATA_W shifts.
                            shreg      <= {rx_s, shreg[DATA_W-1:1]};
                            sample_cnt <= '0;
                            if (bit_cnt == DataLast) begin
                                bit_cnt <= '0;
                                state   <= ParityOn ? StParity : StStop;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    StParity: begin
                        if (sample_cnt == BitLast) begin
                            par_bad    <= ((^shreg) ^ rx_s) != OddBit;
                            sample_cnt <= '0;
                            state      <= StStop;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    StStop: begin
                        if (sample_cnt == BitLast) begin
                            sample_cnt <= '0;
                            par_bad    <= 1'b0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                                state     <= StBreak;
                            end else if (par_bad) begin
                                parity_err <= 1'b1;
                                state      <= StIdle;
                            end else if (wfull) begin
                                overrun_err <= 1'b1;
                                state       <= StIdle;
                            end else begin
                                wrt_en   <= 1'b1;
                                wrt_data <= shreg;
                                state    <= StIdle;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    StBreak: begin
                        if (rx_s) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed plus randomized frame bench for uart_rx_deser (8N1 and 8E1 instances).
module tb_uart_rx_deser;

    localparam int unsigned BitCyc    = 16;
    localparam int          EvFrame   = 'h100;
    localparam int          EvParity  = 'h200;
    localparam int          EvOverrun = 'h300;

    logic        clk = 1'b0;
    logic        wrst;
    logic [15:0] baud_div;
    logic        rx0, rx1, wfull0, wfull1;
    logic        wrt_en0, frame_err0, parity_err0, overrun_err0;
    logic        wrt_en1, frame_err1, parity_err1, overrun_err1;
    logic [7:0]  wrt_data0, wrt_data1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cyc0  = 0;
    int obs0[$];
    int obs1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deser #(
        .DATA_W(8), .OSR(16), .DIV_W(16), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut (
        .wrt_clk(clk), .wrst(wrst), .baud_div(baud_div), .rx_in(rx0), .wfull(wfull0),
        .wrt_en(wrt_en0), .wrt_data(wrt_data0), .frame_err(frame_err0),
        .parity_err(parity_err0), .overrun_err(overrun_err0)
    );

    uart_rx_deser #(
        .DATA_W(8), .OSR(16), .DIV_W(16), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_p (
        .wrt_clk(clk), .wrst(wrst), .baud_div(baud_div), .rx_in(rx1), .wfull(wfull1),
        .wrt_en(wrt_en1), .wrt_data(wrt_data1), .frame_err(frame_err1),
        .parity_err(parity_err1), .overrun_err(overrun_err1)
    );

    // Collect every output pulse as an event code, sampled mid-cycle.
    always @(negedge clk) begin
        if (wrt_en0) begin
            obs0.push_back(int'(wrt_data0));
            wr_cyc0 = cyc;
        end
        if (frame_err0)   obs0.push_back(EvFrame);
        if (parity_err0)  obs0.push_back(EvParity);
        if (overrun_err0) obs0.push_back(EvOverrun);
        if (wrt_en1)      obs1.push_back(int'(wrt_data1));
        if (frame_err1)   obs1.push_back(EvFrame);
        if (parity_err1)  obs1.push_back(EvParity);
        if (overrun_err1) obs1.push_back(EvOverrun);
    end

    // Expected frame outcome from the line-level fields, by the priority rules.
    function automatic int ref_outcome(input logic [7:0] d, input bit par_en, input bit odd,
                                       input bit pbit, input bit stopb, input bit full);
        int ones;
        ones = $countones(d) + (par_en ? int'(pbit) : 0);
        if (!stopb) return EvFrame;
        if (par_en && ((ones % 2) != int'(odd))) return EvParity;
        if (full) return EvOverrun;
        return int'(d);
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx1 = v;
        else     rx0 = v;
    endtask

    task automatic drive_frame(input bit sel, input logic [7:0] d, input bit par_en,
                               input bit pbit, input bit stopb, input int stop_len);
        set_line(sel, 1'b0);
        idle(BitCyc);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            idle(BitCyc);
        end
        if (par_en) begin
            set_line(sel, pbit);
            idle(BitCyc);
        end
        set_line(sel, stopb);
        idle(stop_len * BitCyc);
        set_line(sel, 1'b1);
    endtask

    task automatic expect_one(input bit sel, input string tag, input int expected);
        int got;
        int left;
        if (sel) begin
            got  = (obs1.size() > 0) ? obs1.pop_front() : -1;
            left = obs1.size();
            obs1.delete();
        end else begin
            got  = (obs0.size() > 0) ? obs0.pop_front() : -1;
            left = obs0.size();
            obs0.delete();
        end
        check(tag, got, expected);
        check({tag, "_extra"}, left, 0);
    endtask

    initial begin
        int cs;
        logic [7:0] d;
        bit full, stopb, pbit;
        int exp_ev;

        wrst = 1'b1; baud_div = '0; rx0 = 1'b1; rx1 = 1'b1; wfull0 = 1'b0; wfull1 = 1'b0;
        idle(3);
        check("rst_wrt_en",   int'(wrt_en0), 0);
        check("rst_wrt_data", int'(wrt_data0), 0);
        check("rst_errs",     int'({frame_err0, parity_err0, overrun_err0}), 0);
        check("rst_p_outs",   int'({wrt_en1, frame_err1, parity_err1, overrun_err1}), 0);
        check("rst_p_data",   int'(wrt_data1), 0);
        wrst = 1'b0;
        idle(5);

        cs = cyc;
        drive_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
        expect_one(1'b0, "a5", 'hA5);
        check("a5_latency_ok", int'((wr_cyc0 - cs) >= 154 && (wr_cyc0 - cs) <= 156), 1);
        idle(10);

        // Start-bit glitch shorter than half a bit must be ignored.
        rx0 = 1'b0;
        idle(4);
        rx0 = 1'b1;
        idle(40);
        check("glitch_events", obs0.size(), 0);
        drive_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1);
        expect_one(1'b0, "3c", 'h3C);
        idle(10);

        drive_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 3);
        idle(8);
        expect_one(1'b0, "55_break", EvFrame);
        drive_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1);
        expect_one(1'b0, "81", 'h81);
        idle(10);

        wfull0 = 1'b1;
        drive_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1);
        expect_one(1'b0, "12_overrun", EvOverrun);
        check("data_hold", int'(wrt_data0), 'h81);
        wfull0 = 1'b0;
        idle(10);
        drive_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b1, 1);
        expect_one(1'b0, "34", 'h34);
        idle(10);

        drive_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1);
        expect_one(1'b1, "07_badpar", EvParity);
        idle(10);
        drive_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1);
        expect_one(1'b1, "07_goodpar", 'h07);
        idle(10);

        // Reset in the middle of data bit 4, line released high.
        d = 8'hE6;
        set_line(1'b0, 1'b0);
        idle(BitCyc);
        for (int i = 0; i < 4; i++) begin
            set_line(1'b0, d[i]);
            idle(BitCyc);
        end
        set_line(1'b0, d[4]);
        idle(BitCyc / 2);
        wrst = 1'b1;
        rx0  = 1'b1;
        idle(2);
        wrst = 1'b0;
        check("mid_rst_outs", int'({wrt_en0, frame_err0, parity_err0, overrun_err0}), 0);
        check("mid_rst_data", int'(wrt_data0), 0);
        idle(200);
        check("mid_rst_events", obs0.size(), 0);
        drive_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1);
        drive_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
        check("b2b_count", obs0.size(), 2);
        check("b2b_first",  (obs0.size() > 0) ? obs0[0] : -1, 'hFF);
        check("b2b_second", (obs0.size() > 1) ? obs0[1] : -1, 'h00);
        obs0.delete();
        idle(10);

        for (int i = 0; i < 12; i++) begin
            d      = 8'($urandom_range(0, 255));
            full   = ($urandom_range(0, 3) == 0);
            stopb  = ($urandom_range(0, 4) != 0);
            exp_ev = ref_outcome(d, 1'b0, 1'b0, 1'b0, stopb, full);
            wfull0 = full;
            drive_frame(1'b0, d, 1'b0, 1'b0, stopb, stopb ? 1 : int'($urandom_range(1, 2)));
            expect_one(1'b0, $sformatf("rnd8n1_%0d", i), exp_ev);
            idle(stopb ? int'($urandom_range(0, 10)) : int'($urandom_range(4, 10)));
        end
        wfull0 = 1'b0;

        for (int i = 0; i < 8; i++) begin
            d      = 8'($urandom_range(0, 255));
            pbit   = ($urandom_range(0, 1) == 1);
            exp_ev = ref_outcome(d, 1'b1, 1'b0, pbit, 1'b1, 1'b0);
            drive_frame(1'b1, d, 1'b1, pbit, 1'b1, 1);
            expect_one(1'b1, $sformatf("rnd8e1_%0d", i), exp_ev);
            idle(int'($urandom_range(0, 10)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
UART receive deserializer that sits directly upstream of the RX async FIFO write side and runs entirely in the write clock domain. It oversamples the serial line, recovers start/data/parity/stop framing and issues one-cycle write strobes with a parallel byte into the FIFO. It honours the FIFO full flag and reports framing, parity and overrun errors as single-cycle pulses.

Parameters:
DATA_W, 8, data bits per frame, LSB first
OSR, 16, oversample ticks per bit; even, >=4
DIV_W, 16, width of baud divisor input
PARITY_EN, 0, 1 = one parity bit follows data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0

Ports:
wrt_clk  in  1  write-domain clock
wrst  in  1  asynchronous active-high reset
baud_div  in  DIV_W  wrt_clk cycles per oversample tick minus 1; static except while idle
rx_in  in  1  asynchronous serial line, idle high
wfull  in  1  RX FIFO full flag, write-domain registered
wrt_en  out  1  one-cycle write strobe into FIFO
wrt_data  out  DATA_W  received byte, valid when wrt_en=1
frame_err  out  1  one-cycle pulse: stop bit sampled low
parity_err  out  1  one-cycle pulse: parity mismatch
overrun_err  out  1  one-cycle pulse: good frame dropped because wfull=1

Behaviour:
- Reset (async, wrst=1): state IDLE; sync flops, shift register, counters = 0 except sync flops = 1; wrt_en, frame_err, parity_err, overrun_err = 0; wrt_data = 0.
- rx_in passes through 2-flop synchronizer (rx_s); all decisions use rx_s.
- Tick generator: counter 0..baud_div, tick=1 for one cycle when count==baud_div then wraps to 0; baud_div=0 gives tick every cycle; free-running, not realigned by start edge.
- All state/counter changes below occur only on tick cycles; sample_cnt range 0..OSR-1, bit_cnt range 0..DATA_W-1.
- IDLE: rx_s=0 -> START, sample_cnt=0.
- START: sample_cnt increments; at sample_cnt==OSR/2-1: rx_s=1 -> IDLE (glitch, no output); rx_s=0 -> DATA, sample_cnt=0, bit_cnt=0.
- DATA: at sample_cnt==OSR-1 shift rx_s into MSB of shift reg (LSB-first receive), sample_cnt=0, bit_cnt++; after bit DATA_W-1 -> PARITY if PARITY_EN else STOP.
- PARITY: at sample_cnt==OSR-1 capture parity bit; error if XOR(data,parity) != PARITY_ODD; -> STOP.
- STOP: at sample_cnt==OSR-1 (mid stop bit) sample rx_s, then exactly one outcome, evaluated in priority order:
  1) rx_s=0: frame_err pulse, no write, -> BREAK.
  2) parity error: parity_err pulse, no write, -> IDLE.
  3) wfull=1: overrun_err pulse, no write, -> IDLE.
  4) else wrt_en=1 with wrt_data=shift reg, -> IDLE.
- BREAK: wait for rx_s=1 (on tick), then -> IDLE; prevents retrigger on held-low line.
- Output pulses are registered: asserted the wrt_clk cycle after the deciding tick, exactly one cycle wide; wrt_data holds until next write.
- Frame-to-output latency from first rx_s falling edge: (OSR/2 + (1+DATA_W+PARITY_EN)*OSR) ticks, +1 cycle, +/- one tick alignment, + 2 sync cycles.
- wfull sampled only at the decision tick; wrt_en never asserted while wfull=1 that cycle.
- Reset mid-frame: partial frame discarded, no pulses; next full frame received normally.
- Back-to-back frames with no idle gap after stop bit are received correctly (IDLE entered at mid-stop).

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK), default OSR, DATA_W constants.
- Sub-module uart_baud_tick (divisor counter, tick output, same clock/reset). Synchronizer and FSM inline.

Test Plan:
- baud_div=0, OSR=16, send 0xA5 (8N1) -> single wrt_en pulse, wrt_data=0xA5, no error pulses, latency 152 ticks +/- 1 from start edge.
- rx_in low for 4 ticks then high -> returns IDLE, no wrt_en, no errors; subsequent 0x3C received correctly.
- Send 0x55 with stop bit held 0 for 3 bit times -> one frame_err pulse, no wrt_en, no new frame until line high; following 0x81 received.
- wfull=1 during 0x12 frame -> one overrun_err pulse, wrt_en stays 0; wfull=0 next frame 0x34 -> written.
- PARITY_EN=1, PARITY_ODD=0: 0x07 with parity bit 0 -> parity_err, no write; with parity 1 -> write 0x07.
- Assert wrst for 2 cycles mid data bit 4 -> all outputs 0, IDLE; two back-to-back frames 0xFF, 0x00 -> two wrt_en pulses in order.
